// File: rtl/updn_mod_counter_pkg.sv
// Shared constants for the up/down modulo counter family.
package updn_mod_counter_pkg;

    // Direction encoding on the up_dn input.
    localparam bit DIR_UP   = 1'b1;
    localparam bit DIR_DOWN = 1'b0;

    // Boundary behaviour selected by the SATURATE parameter.
    localparam bit MODE_WRAP = 1'b0;
    localparam bit MODE_SAT  = 1'b1;

endpackage : updn_mod_counter_pkg

// File: rtl/updn_prescaler.sv
// Enable prescaler: produces one tick per DIV enabled cycles.
// Holds while en is low; clr discards any partial progress.
module updn_prescaler #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Tick on the last enabled cycle of each DIV-long window.
    assign tick = en && (cnt_q == LAST);

    // Next prescale count: clear wins, otherwise advance only when enabled.
    always_comb begin
        // NOTE: default assignment first so every path drives cnt_d; no latch.
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
        end
    end

    // Prescale count register with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments for all registered state.
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : updn_prescaler

// File: rtl/updn_mod_counter.sv
// Up/down modulo counter with load clamp, optional saturation,
// enable prescaler and a registered terminal-count pulse.
module updn_mod_counter
    import updn_mod_counter_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] MAX_VAL   = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] RESET_VAL = MAX_VAL,
    parameter bit               SATURATE  = MODE_WRAP,
    parameter int               DIV       = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             tc_q;
    logic             tc_d;
    logic             tick;
    logic             step;

    // Load restarts the prescale window so the next step is a full DIV away.
    updn_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .clr   (load),
        .tick  (tick)
    );

    // tick already implies en; load suppresses the step.
    assign step = tick && !load;

    // Next count and terminal-count: load beats step, boundaries wrap or hold.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (load) begin
            count_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (step) begin
            if (up_dn == DIR_UP) begin
                if (count_q == MAX_VAL) begin
                    tc_d    = 1'b1;
                    count_d = (SATURATE == MODE_SAT) ? MAX_VAL : '0;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == '0) begin
                    tc_d    = 1'b1;
                    count_d = (SATURATE == MODE_SAT) ? '0 : MAX_VAL;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    // Count and terminal-count registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= RESET_VAL;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign zero  = (count_q == '0);

endmodule : updn_mod_counter

// File: tb/tb_updn_mod_counter.sv
// Self-checking bench: four counter configurations share one stimulus
// stream and are compared every cycle against a behavioural model.
module tb_updn_mod_counter;

    localparam int N = 4;
    // u0: defaults; u1: MAX 9 wrap; u2: MAX 9 saturate; u3: MAX 9, DIV 3, reset value 2
    localparam int MAXV [N] = '{15, 9, 9, 9};
    localparam int RSTV [N] = '{15, 9, 9, 2};
    localparam int SATV [N] = '{0, 0, 1, 0};
    localparam int DIVV [N] = '{1, 1, 1, 3};

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [3:0] load_val;

    logic [3:0] cnt_o  [N];
    logic       tc_o   [N];
    logic       zero_o [N];

    int m_cnt [N];
    int m_pre [N];
    int m_tc  [N];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    updn_mod_counter u0 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .count(cnt_o[0]), .tc(tc_o[0]), .zero(zero_o[0])
    );

    updn_mod_counter #(.WIDTH(4), .MAX_VAL(4'd9)) u1 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .count(cnt_o[1]), .tc(tc_o[1]), .zero(zero_o[1])
    );

    updn_mod_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b1)) u2 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .count(cnt_o[2]), .tc(tc_o[2]), .zero(zero_o[2])
    );

    updn_mod_counter #(.WIDTH(4), .MAX_VAL(4'd9), .RESET_VAL(4'd2), .DIV(3)) u3 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .count(cnt_o[3]), .tc(tc_o[3]), .zero(zero_o[3])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s u%0d count", tag, i), 32'(cnt_o[i]), m_cnt[i]);
            check($sformatf("%s u%0d tc", tag, i), 32'(tc_o[i]), m_tc[i]);
            check($sformatf("%s u%0d zero", tag, i), 32'(zero_o[i]), (m_cnt[i] == 0) ? 1 : 0);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = RSTV[i];
            m_pre[i] = 0;
            m_tc[i]  = 0;
        end
    endtask

    // Reference behaviour: count enabled cycles; every DIV-th one is a step.
    task automatic model_edge();
        if (reset) begin
            model_reset();
            return;
        end
        for (int i = 0; i < N; i++) begin
            m_tc[i] = 0;
            if (load) begin
                m_cnt[i] = (int'(load_val) > MAXV[i]) ? MAXV[i] : int'(load_val);
                m_pre[i] = 0;
            end else if (en) begin
                m_pre[i] = m_pre[i] + 1;
                if (m_pre[i] == DIVV[i]) begin
                    m_pre[i] = 0;
                    if (up_dn) begin
                        if (m_cnt[i] == MAXV[i]) begin
                            m_tc[i]  = 1;
                            m_cnt[i] = SATV[i] ? MAXV[i] : 0;
                        end else begin
                            m_cnt[i] = m_cnt[i] + 1;
                        end
                    end else begin
                        if (m_cnt[i] == 0) begin
                            m_tc[i]  = 1;
                            m_cnt[i] = SATV[i] ? 0 : MAXV[i];
                        end else begin
                            m_cnt[i] = m_cnt[i] - 1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic set_in(input logic e, input logic d, input logic l, input logic [3:0] v);
        en       = e;
        up_dn    = d;
        load     = l;
        load_val = v;
    endtask

    initial begin
        // Reset state, then count down from the reset value through the wrap.
        reset = 1'b1;
        set_in(1'b1, 1'b0, 1'b0, 4'd0);
        model_reset();
        #2;
        check_all("reset");
        #8;
        reset = 1'b0;
        for (int k = 0; k < 18; k++) cycle("down_wrap");

        // Load 7 then count up through the MAX 9 wrap.
        set_in(1'b0, 1'b1, 1'b1, 4'd7);
        cycle("load7");
        set_in(1'b1, 1'b1, 1'b0, 4'd0);
        for (int k = 0; k < 6; k++) cycle("up_from7");

        // Out-of-range load with en high: clamp, no step, tc low.
        set_in(1'b1, 1'b1, 1'b1, 4'd12);
        cycle("load12_clamp");

        // Saturating top: three up steps at 9, then one step down.
        set_in(1'b0, 1'b1, 1'b1, 4'd9);
        cycle("load9");
        set_in(1'b1, 1'b1, 1'b0, 4'd0);
        for (int k = 0; k < 3; k++) cycle("sat_up");
        up_dn = 1'b0;
        cycle("sat_down");

        // Prescaled counting with en dropped mid-window.
        set_in(1'b1, 1'b0, 1'b0, 4'd0);
        for (int k = 0; k < 4; k++) cycle("div3_run");
        en = 1'b0;
        for (int k = 0; k < 2; k++) cycle("div3_hold");
        en = 1'b1;
        for (int k = 0; k < 5; k++) cycle("div3_resume");

        // Asynchronous reset between edges with count 5 and prescaler mid-window.
        set_in(1'b0, 1'b0, 1'b1, 4'd5);
        cycle("load5");
        set_in(1'b1, 1'b0, 1'b0, 4'd0);
        cycle("pre_mid");
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all("async_reset");
        cycle("reset_held");
        #2;
        reset = 1'b0;
        for (int k = 0; k < 7; k++) cycle("post_reset");

        // Randomised traffic against the model.
        for (int k = 0; k < 400; k++) begin
            set_in(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)));
            cycle("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_updn_mod_counter

// File: doc/updn_mod_counter.md
UPDN_MOD_COUNTER -- requirements
Module: updn_mod_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter width in bits (1..32).
REQ-002 SHALL have parameter MAX_VAL, default 2**WIDTH-1, top of count range (1..2**WIDTH-1).
REQ-003 SHALL have parameter RESET_VAL, default MAX_VAL, count value after reset (0..MAX_VAL).
REQ-004 SHALL have parameter SATURATE, default 0: 0 = wrap at boundaries, 1 = hold at boundaries.
REQ-005 SHALL have parameter DIV, default 1, prescale ratio: one step per DIV enabled cycles (1..256).
REQ-006 clk  input  1  clock; all state changes on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 en  input  1  count enable; advances the prescaler.
REQ-009 up_dn  input  1  direction: 1 = up, 0 = down.
REQ-010 load  input  1  synchronous load strobe.
REQ-011 load_val  input  WIDTH  value to load.
REQ-012 count  output  WIDTH  registered counter value.
REQ-013 tc  output  1  registered terminal-count pulse.
REQ-014 zero  output  1  combinational, high when count == 0.

Function
REQ-015 Define step = en && tick, where tick comes from the prescaler (REQ-024); with DIV=1, tick = 1 every cycle.
REQ-016 Priority SHALL be load over step; with load high, no step occurs that cycle and the prescaler clears.
REQ-017 On load, count SHALL become load_val if load_val <= MAX_VAL, otherwise MAX_VAL (clamp); tc SHALL be 0 that cycle.
REQ-018 Up step, count < MAX_VAL: count += 1.
REQ-019 Up step, count == MAX_VAL: count SHALL become 0 (SATURATE=0) or hold at MAX_VAL (SATURATE=1).
REQ-020 Down step, count > 0: count -= 1.
REQ-021 Down step, count == 0: count SHALL become MAX_VAL (SATURATE=0) or hold at 0 (SATURATE=1).
REQ-022 tc SHALL be 1 for exactly one cycle after any step taken at a boundary (REQ-019/021), in both SATURATE modes; otherwise 0.
REQ-023 up_dn SHALL be sampled at each step only; a direction change applies to the next step, with no extra latency.
REQ-024 Prescaler SHALL count enabled cycles 0..DIV-1 and assert tick when at DIV-1 with en high, then return to 0; it SHALL hold while en is low.
REQ-025 Without step or load, count and the prescaler state SHALL hold, and tc SHALL be 0.
REQ-026 All arithmetic SHALL be WIDTH bits wide, with no intermediate overflow; count SHALL never exceed MAX_VAL.

Reset
REQ-027 reset SHALL asynchronously force count = RESET_VAL, tc = 0 and prescaler = 0, independent of clk.
REQ-028 Reset asserted mid-prescale or mid-count SHALL discard any partial prescale progress.
REQ-029 After reset deasserts, the first step SHALL occur on the DIV-th enabled rising edge.

Structure
REQ-030 A shared package SHALL hold the direction constants (DIR_UP = 1, DIR_DOWN = 0) and the mode constants (MODE_WRAP = 0, MODE_SAT = 1).
REQ-031 The prescaler SHALL be a sub-module named updn_prescaler (params DIV; ports clk, reset, en, clr, tick).
REQ-032 The boundary-detect and next-count logic SHALL live in updn_mod_counter.

Verification
REQ-033 Defaults, reset 10 ns then en=1, up_dn=0: count 15,14,...,0,15 on successive edges; tc pulses once, on the cycle after the 0->15 wrap.
REQ-034 WIDTH=4, MAX_VAL=9, up_dn=1, load_val=7, load=1 for one cycle: count 7,8,9,0,1; tc high only on the cycle after 9->0.
REQ-035 SATURATE=1, MAX_VAL=9, count=9, up for 3 steps: count stays 9; tc pulses on each of the 3 cycles following those steps; then down for 1 step gives 8.
REQ-036 DIV=3, en=1: count changes every 3rd edge; en low for 2 cycles mid-prescale extends that interval by exactly 2 cycles.
REQ-037 MAX_VAL=9, load_val=12 with load=1 and en=1 in the same cycle: count = 9, no step, tc = 0.
REQ-038 Assert reset asynchronously between clock edges while count=5, DIV=3, prescaler mid-way: count = RESET_VAL immediately; the first step comes 3 enabled edges after release.
